// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: word count, MSB-first words, optional XOR checksum.
// Checksum byte and CHECK state exist only when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHECK;
`else
  localparam state_t S_END = S_DONE;
`endif

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] widx_q, widx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] asm_q, asm_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        xfer;
  logic [15:0] n_rx;

  always_comb begin
    rx_ready  = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                || (state_q == S_CHECK)
`endif
                ;
    busy      = rx_ready;
    done      = (state_q == S_DONE);
    error     = (state_q == S_ERROR);
    cpu_reset = (state_q != S_DONE);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

  assign xfer = rx_valid && rx_ready;
  assign n_rx = {count_q[15:8], rx_data};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    if (xfer) csum_d = csum_q ^ rx_data;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_CNT_HI;
          count_d = '0;
          widx_d  = '0;
          bcnt_d  = '0;
          asm_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          count_d[15:8] = rx_data;
          state_d       = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (xfer) begin
          count_d[7:0] = rx_data;
          if (n_rx == 16'd0)               state_d = S_END;
          else if ({16'd0, n_rx} > MAX_W)  state_d = S_ERROR;
          else                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          bcnt_d = bcnt_q + 2'd1;
          asm_d  = {asm_q[15:0], rx_data};
          if (bcnt_q == 2'd3) begin
            // Strobe is registered, so it lands in the cycle after the 4th byte.
            we_d    = 1'b1;
            wdata_d = {asm_q, rx_data};
            addr_d  = ADDR_BASE + {14'd0, widx_q, 2'b00};
            widx_d  = widx_q + 16'd1;
            if (widx_q == count_q - 16'd1) state_d = S_END;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= ADDR_BASE;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-level write scoreboard plus per-cycle status rules.
// Honours IMEM_LOADER_CHECKSUM_EN to decide whether a checksum byte is sent.
module tb_imem_loader;

  localparam logic [31:0] ADDR_BASE = 32'h0000_0000;
  localparam int unsigned MAX_WORDS = 256;

  logic        clock, reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_we, cpu_reset, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader #(.ADDR_BASE(ADDR_BASE), .MAX_WORDS(MAX_WORDS)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int unsigned due; logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t expq[$];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  logic [31:0] last_addr, last_data;
  logic [31:0] prog [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the stream model's expected writes and status rules.
  always @(negedge clock) begin
    if (chk_en) begin
      check("cpu_reset_rule", {31'd0, cpu_reset}, {31'd0, ~done});
      check("ready_eq_busy", {31'd0, rx_ready}, {31'd0, busy});
      check("done_error_excl", {31'd0, done & error}, 32'd0);
      while (expq.size() > 0 && expq[0].due < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL write_missing: addr %h data %h due %0d not seen by %0d",
                 expq[0].addr, expq[0].data, expq[0].due, cyc);
        last_addr = expq[0].addr;
        last_data = expq[0].data;
        void'(expq.pop_front());
      end
      if (mem_we) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL write_unexpected: addr %h data %h want no write", mem_addr, mem_wdata);
        end else begin
          check("write_cycle", cyc, expq[0].due);
          check("write_addr", mem_addr, expq[0].addr);
          check("write_data", mem_wdata, expq[0].data);
          last_addr = expq[0].addr;
          last_data = expq[0].data;
          void'(expq.pop_front());
        end
      end else begin
        check("addr_hold", mem_addr, last_addr);
        check("data_hold", mem_wdata, last_data);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int unsigned gap, output int unsigned acc);
    int unsigned n;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 16) begin @(posedge clock); #1; n++; end
    if (!rx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL rx_ready_timeout: ready 0 want 1 for byte %h", b);
      rx_valid = 1'b0;
      acc = cyc;
    end else begin
      @(posedge clock); #1;
      acc = cyc;
      rx_valid = 1'b0;
    end
  endtask

  task automatic load(input logic [15:0] n, input int unsigned gap, input bit bad_ck, input bit poke);
    logic [7:0] x, b;
    int unsigned acc;
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("status_clear", {30'd0, done, error}, 32'd0);
    x = n[15:8] ^ n[7:0];
    send(n[15:8], gap, acc);
    send(n[7:0], gap, acc);
    if (32'(n) > MAX_WORDS) begin
      check("err_after_cnt", {31'd0, error}, 32'd1);
      check("done_after_cnt", {31'd0, done}, 32'd0);
      check("cpu_reset_err", {31'd0, cpu_reset}, 32'd1);
      check("busy_err", {31'd0, busy}, 32'd0);
    end else begin
      if (poke && n != 16'd0) begin
        pulse_start();
        check("start_ignored", {31'd0, busy}, 32'd1);
      end
      for (int unsigned k = 0; k < 32'(n); k++) begin
        for (int unsigned j = 0; j < 4; j++) begin
          b = prog[k][31-8*j -: 8];
          x ^= b;
          send(b, gap, acc);
          if (j == 3) expq.push_back('{due: acc, addr: ADDR_BASE + 32'(4*k), data: prog[k]});
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(bad_ck ? ~x : x, gap, acc);
      check("done_final", {31'd0, done}, {31'd0, ~bad_ck});
      check("error_final", {31'd0, error}, {31'd0, bad_ck});
      check("cpu_reset_final", {31'd0, cpu_reset}, {31'd0, bad_ck});
`else
      check("done_final", {31'd0, done}, 32'd1);
      check("error_final", {31'd0, error}, {31'd0, bad_ck});
      check("cpu_reset_final", {31'd0, cpu_reset}, 32'd0);
`endif
    end
    repeat (2) begin @(posedge clock); #1; end
    check("writes_drained", expq.size(), 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    for (int unsigned k = 0; k < 64; k++)
      prog[k] = {8'h20 + 8'(k), 8'hA5 ^ 8'(k), 16'(k * 37 + 1)};
    prog[0] = 32'h201D_0100;
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    last_addr = ADDR_BASE;
    last_data = 32'd0;
    chk_en = 1'b1;
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_error", {30'd0, done, error}, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0000_0000);
    check("rst_mem_wdata", mem_wdata, 32'h0000_0000);

    // 44-word program
    load(16'h002C, 0, 1'b0, 1'b0);
    check("fib_last_addr", mem_addr, 32'h0000_00AC);
    check("fib_done", {31'd0, done}, 32'd1);

    // Empty program
    load(16'h0000, 0, 1'b0, 1'b0);

    // Oversized count
    load(16'(MAX_WORDS + 1), 0, 1'b0, 1'b0);

    // Single word with gaps and an ignored mid-load start
    prog[0] = 32'h2008_0006;
    load(16'h0001, 3, 1'b0, 1'b1);
    check("gap_wdata", mem_wdata, 32'h2008_0006);
    check("gap_addr", mem_addr, 32'h0000_0000);

    // Reset after 2 bytes of word 3
    pulse_start();
    send(8'h00, 0, acc);
    send(8'h05, 0, acc);
    for (int unsigned k = 0; k < 3; k++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        send(prog[k+8][31-8*j -: 8], 0, acc);
        if (j == 3) expq.push_back('{due: acc, addr: ADDR_BASE + 32'(4*k), data: prog[k+8]});
      end
    end
    send(prog[11][31:24], 0, acc);
    send(prog[11][23:16], 0, acc);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    last_addr = ADDR_BASE;
    last_data = 32'd0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_addr", mem_addr, 32'h0000_0000);
    check("mid_rst_wdata", mem_wdata, 32'h0000_0000);
    @(posedge clock); #1;
    load(16'h0002, 0, 1'b0, 1'b0);
    check("post_rst_addr", mem_addr, 32'h0000_0004);

`ifdef IMEM_LOADER_CHECKSUM_EN
    load(16'h0003, 0, 1'b1, 1'b0);
    check("bad_ck_error", {31'd0, error}, 32'd1);
    load(16'h0003, 1, 1'b0, 1'b0);
    check("recover_done", {31'd0, done}, 32'd1);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, byte address of the first written instruction word.
REQ-002 SHALL have parameter MAX_WORDS, default 256, largest accepted word count (instruction memory depth).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
REQ-006 SHALL have port rx_valid  input  1  rx_data carries a byte.
REQ-007 SHALL have port rx_data  input  8  stream byte.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte; a byte transfers when rx_valid and rx_ready are both high.
REQ-009 SHALL have port mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  32  byte address of the write; always word aligned.
REQ-011 SHALL have port mem_wdata  output  32  instruction word.
REQ-012 SHALL have port cpu_reset  output  1  active-high hold applied to the cpu reset input.
REQ-013 SHALL have ports busy, done, error  output  1 each  status flags.

Function
REQ-014 Stream format SHALL be: count_hi, count_lo (16-bit word count N, MSB first), then N words of 4 bytes, each MSB first, then an optional checksum byte (REQ-032).
REQ-015 States SHALL be IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE and ERROR.
REQ-016 start in IDLE, DONE or ERROR SHALL move to CNT_HI and clear done, error, byte counter and checksum; start in any other state SHALL be ignored.
REQ-017 rx_ready SHALL be 1 exactly in CNT_HI, CNT_LO, DATA and CHECK; each accepted byte SHALL advance the state by one byte, and idle cycles (rx_valid low) SHALL not change state.
REQ-018 After CNT_LO: N=0 SHALL go to CHECK (or DONE when the checksum is compiled out) with no write; N>MAX_WORDS SHALL go to ERROR; otherwise SHALL go to DATA.
REQ-019 The 4th byte of word k (k from 0) SHALL cause mem_we=1 in the next cycle only, with mem_addr=ADDR_BASE+4*k and mem_wdata set to the assembled word.
REQ-020 mem_addr SHALL be computed modulo 2^32; mem_addr and mem_wdata SHALL hold their values while mem_we=0.
REQ-021 After word N-1 is accepted, the state SHALL go to CHECK (or DONE when the checksum is compiled out); the final write strobe SHALL still fire in the following cycle.
REQ-022 In DONE: done=1 and cpu_reset=0. In ERROR: error=1 and cpu_reset=1. Both SHALL persist until start or reset.
REQ-023 busy SHALL be 1 in CNT_HI, CNT_LO, DATA and CHECK; cpu_reset SHALL be 1 in every state except DONE.
REQ-024 done and error SHALL never both be 1.

Reset
REQ-025 reset=0 at a clock edge SHALL force IDLE in any state, including mid-word.
REQ-026 Reset SHALL drive mem_we=0, mem_addr=ADDR_BASE, mem_wdata=0, rx_ready=0, busy=0, done=0, error=0 and cpu_reset=1.
REQ-027 Reset SHALL discard partially assembled words, and no write SHALL issue in the cycle after reset.

Configuration
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN SHALL select checksum support.
REQ-029 When defined, the loader SHALL keep a running 8-bit XOR of all count and payload bytes.
REQ-030 When defined, CHECK SHALL accept one byte: equal to the running XOR goes to DONE, unequal goes to ERROR.
REQ-031 When defined, words already written SHALL remain written on a checksum mismatch.
REQ-032 When undefined, there SHALL be no CHECK state, no checksum byte is consumed, and the last word goes directly to DONE.

Verification
REQ-033 Load the 44-word Fibonacci program (N=0x002C, first word 0x201D0100, correct XOR): 44 strobes at addresses 0..0xAC, done=1, cpu_reset=0; after release, cpu register 8 SHALL equal 144.
REQ-034 N=0 with checksum 0x00: no mem_we pulses; done=1 two accepted bytes after start (three with the checksum).
REQ-035 N=MAX_WORDS+1: error=1 in the cycle after count_lo is accepted, no writes, cpu_reset=1.
REQ-036 Stream 20 08 00 06 with rx_valid dropped for 3 cycles between bytes: single write, mem_wdata=0x20080006, mem_addr=ADDR_BASE.
REQ-037 reset=0 after 2 bytes of word 3, then a full new load: first write at ADDR_BASE, no stale data.
REQ-038 (IMEM_LOADER_CHECKSUM_EN defined) Corrupt the checksum byte: error=1 and done=0; a following start plus a valid stream SHALL reach done=1.
